load_access_sequencer: RTL

//  Multicycle load sequencer between the core's load issue point and the word-wide data bus.

---
 rtl/load_access_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/load_access_sequencer.sv
// Multicycle load sequencer: decode, alignment check, bus read(s), lane extract and extend.
// Optional two-read misaligned support when LOAD_MISALIGNED_SPLIT_EN is defined.
module load_access_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic        req_amo,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err_misaligned,
  output logic        rsp_err_illegal,
  output logic        rsp_err_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StMem0, StMem1, StResp} state_e;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  // Counter only needs to reach TIMEOUT_CYCLES-1; the final wait cycle is detected combinationally.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             err_mis_q, err_mis_d;
  logic             err_ill_q, err_ill_d;
  logic             err_to_q, err_to_d;

  logic [1:0]       req_size;
  logic             req_uns;
  logic             req_illegal;
  logic             req_misaligned;
  logic             split_ok;
  logic             timeout_hit;
  logic [63:0]      rd_pair;
  logic             last_read;

`ifdef LOAD_MISALIGNED_SPLIT_EN
  logic             split_q, split_d;
  logic [31:0]      rdata0_q, rdata0_d;
`endif

  function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off,
                                          input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    logic [31:0] res;
    sh = pair >> {off, 3'b000};
    case (size)
      SzByte:  res = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SzHalf:  res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = sh[31:0];
    endcase
    return res;
  endfunction

  always_comb begin
    req_size    = SzWord;
    req_uns     = 1'b0;
    req_illegal = 1'b0;
    if (!req_amo) begin
      unique case (req_funct3)
        3'b000:  req_size = SzByte;
        3'b001:  req_size = SzHalf;
        3'b010:  req_size = SzWord;
        3'b100:  begin req_size = SzByte; req_uns = 1'b1; end
        3'b101:  begin req_size = SzHalf; req_uns = 1'b1; end
        default: req_illegal = 1'b1;
      endcase
    end
    req_misaligned = ((req_size == SzHalf) && req_addr[0]) ||
                     ((req_size == SzWord) && (req_addr[1:0] != 2'b00));
  end

`ifdef LOAD_MISALIGNED_SPLIT_EN
  assign split_ok  = !req_amo;
  assign last_read = (state_q == StMem1) || !split_q;
  assign rd_pair   = (state_q == StMem1) ? {mem_rdata, rdata0_q} : {32'h0, mem_rdata};
  assign mem_addr  = {addr_q[31:2] + {29'h0, state_q == StMem1}, 2'b00};
`else
  assign split_ok  = 1'b0;
  assign last_read = 1'b1;
  assign rd_pair   = {32'h0, mem_rdata};
  assign mem_addr  = {addr_q[31:2], 2'b00};
`endif

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    err_mis_d = err_mis_q;
    err_ill_d = err_ill_q;
    err_to_d  = err_to_q;
`ifdef LOAD_MISALIGNED_SPLIT_EN
    split_d   = split_q;
    rdata0_d  = rdata0_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d = req_addr;
          size_d = req_size;
          uns_d  = req_uns;
          cnt_d  = '0;
          data_d = '0;
`ifdef LOAD_MISALIGNED_SPLIT_EN
          split_d = req_misaligned;
`endif
          if (req_illegal) begin
            err_ill_d = 1'b1;
            state_d   = StResp;
          end else if (req_misaligned && !split_ok) begin
            err_mis_d = 1'b1;
            state_d   = StResp;
          end else begin
            state_d = StMem0;
          end
        end
      end
      StMem0, StMem1: begin
        if (mem_ready) begin
          cnt_d = '0;
          if (last_read) begin
            data_d  = extract(rd_pair, addr_q[1:0], size_q, uns_q);
            state_d = StResp;
          end else begin
`ifdef LOAD_MISALIGNED_SPLIT_EN
            rdata0_d = mem_rdata;
`endif
            state_d = StMem1;
          end
        end else if (timeout_hit) begin
          err_to_d = 1'b1;
          data_d   = '0;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          data_d    = '0;
          err_mis_d = 1'b0;
          err_ill_d = 1'b0;
          err_to_d  = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= SzWord;
      uns_q     <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      err_mis_q <= 1'b0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      err_mis_q <= err_mis_d;
      err_ill_q <= err_ill_d;
      err_to_q  <= err_to_d;
    end
  end

`ifdef LOAD_MISALIGNED_SPLIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_q  <= 1'b0;
      rdata0_q <= '0;
    end else begin
      split_q  <= split_d;
      rdata0_q <= rdata0_d;
    end
  end
`endif

  assign req_ready          = (state_q == StIdle);
  assign mem_valid          = (state_q == StMem0) || (state_q == StMem1);
  assign rsp_valid          = (state_q == StResp);
  assign busy               = (state_q != StIdle);
  assign rsp_data           = data_q;
  assign rsp_err_misaligned = err_mis_q;
  assign rsp_err_illegal    = err_ill_q;
  assign rsp_err_timeout    = err_to_q;

endmodule
